// File: rtl/if_id_queue.sv
// IF/ID boundary: DEPTH-entry circular instruction queue with valid/ready on both sides,
// redirect flush with wrong-path drop, and WFI bubbles. Optional same-cycle bypass: IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
   parameter int          XLEN       = 32,
   parameter int          DEPTH      = 4,
   parameter int          FLUSH_DROP = 1,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       if_valid,
   input  logic [XLEN-1:0]            if_pc,
   input  logic [31:0]                if_instr,
   output logic                       if_ready,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [XLEN-1:0]            id_pc,
   output logic [31:0]                id_instr,
   input  logic                       flush,
   input  logic                       interrupt,
   input  logic                       wfi,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = (FLUSH_DROP > 0) ? $clog2(FLUSH_DROP + 1) : 1;
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [DW-1:0] DROP_LOAD = DW'(FLUSH_DROP);

   logic [XLEN-1:0] r_memPc    [DEPTH];
   logic [31:0]     r_memInstr [DEPTH];
   logic [AW-1:0]   r_wrPtr;
   logic [AW-1:0]   r_rdPtr;
   logic [CW-1:0]   r_count;
   logic [DW-1:0]   r_drop;
   logic [XLEN-1:0] r_holdPc;

   logic w_redirect;
   logic w_dropping;
   logic w_notEmpty;
   logic w_push;
   logic w_pop;
   logic w_write;
   logic w_bypassTake;

   assign w_redirect = flush | interrupt;
   assign w_dropping = (r_drop != '0);
   assign w_notEmpty = (r_count != '0);
   assign if_ready   = (r_count != FULL);
   assign count      = r_count;
   assign w_push     = if_valid & if_ready;
   assign w_pop      = id_ready & w_notEmpty & ~wfi & ~w_redirect;

`ifdef IF_ID_QUEUE_BYPASS_EN
   logic w_bypass;
   assign w_bypass     = ~w_notEmpty & ~w_dropping & if_valid & ~w_redirect & ~wfi;
   assign w_bypassTake = w_bypass & id_ready;
`else
   assign w_bypassTake = 1'b0;
`endif

   // Words arriving during a redirect or inside the drop window are accepted but never stored.
   assign w_write = w_push & ~w_redirect & ~w_dropping & ~w_bypassTake;

   always_comb begin
      id_valid = 1'b0;
      id_pc    = r_holdPc;
      id_instr = NOP_INSTR;
      if (w_redirect) begin
         id_valid = 1'b0;
      end else if (wfi) begin
         id_valid = 1'b1;
      end else if (w_notEmpty) begin
         id_valid = 1'b1;
         id_pc    = r_memPc[r_rdPtr];
         id_instr = r_memInstr[r_rdPtr];
      end
`ifdef IF_ID_QUEUE_BYPASS_EN
      else if (w_bypass) begin
         id_valid = 1'b1;
         id_pc    = if_pc;
         id_instr = if_instr;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_memPc[r_wrPtr]    <= if_pc;
         r_memInstr[r_wrPtr] <= if_instr;
      end
   end

   // A redirect empties the queue by snapping the read pointer onto the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_count  <= '0;
         r_drop   <= '0;
         r_holdPc <= '0;
      end else if (w_redirect) begin
         r_count <= '0;
         r_rdPtr <= r_wrPtr;
         r_drop  <= DROP_LOAD;
      end else begin
         if (w_write) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)   r_rdPtr <= r_rdPtr + AW'(1);
         if (w_push && w_dropping) r_drop <= r_drop - DW'(1);
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop)             r_holdPc <= r_memPc[r_rdPtr];
         else if (w_bypassTake) r_holdPc <= if_pc;
      end
   end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed pushes queue expected words, a monitor checks pops.
module tb_if_id_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            if_ready;
   logic            id_ready;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [31:0]     id_instr;
   logic            flush;
   logic            interrupt;
   logic            wfi;
   logic [2:0]      count;

   int checks   = 0;
   int failures = 0;
   logic [63:0] sbq[$];

   if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_DROP(1), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
      .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
      .flush(flush), .interrupt(interrupt), .wfi(wfi), .count(count)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] pc, input bit keep);
      if_valid = v;
      if_pc    = pc;
      if_instr = 32'h1000_0000 | pc;
      if (v && keep) sbq.push_back({pc, 32'h1000_0000 | pc});
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drainWait(input string name);
      int n;
      n = 0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      id_ready = 1'b1;
      @(negedge clk);
      while (count != 0 && n < 20) begin
         tick;
         @(negedge clk);
         n++;
      end
      checkOutput(name, 64'(count), 64'd0);
      tick;
   endtask

   // Every handshake the decode side completes must match the oldest outstanding expected word.
   initial begin : monitor
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n && id_valid && id_ready && !wfi && !flush && !interrupt) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_pop: got pc 0x%0h expected no pop", id_pc);
            end else begin
               exp = sbq.pop_front();
               checkOutput("pop_pc", 64'(id_pc), 64'(exp[63:32]));
               checkOutput("pop_instr", 64'(id_instr), 64'(exp[31:0]));
            end
         end
      end
   end

   initial begin : stimulus
      int          modelCount;
      logic [31:0] pc;
      bit          rdy;
      bit          canPush;
      rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
      id_ready = 1'b0; flush = 1'b0; interrupt = 1'b0; wfi = 1'b0;

      @(negedge clk);
      checkOutput("rst_if_ready", 64'(if_ready), 64'd1);
      checkOutput("rst_id_valid", 64'(id_valid), 64'd0);
      checkOutput("rst_id_instr", 64'(id_instr), 64'h13);
      checkOutput("rst_id_pc", 64'(id_pc), 64'd0);
      checkOutput("rst_count", 64'(count), 64'd0);
      tick;
      rst_n = 1'b1;

      $display("[TB] streaming");
      id_ready = 1'b1;
      applyStimulus(1'b1, 32'h00, 1'b1); tick;
      applyStimulus(1'b1, 32'h04, 1'b1);
      @(negedge clk);
      checkOutput("stream_valid", 64'(id_valid), 64'd1);
      checkOutput("stream_count0", 64'(count), 64'd1);
      tick;
      applyStimulus(1'b1, 32'h08, 1'b1);
      @(negedge clk); checkOutput("stream_count1", 64'(count), 64'd1); tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk); checkOutput("stream_count2", 64'(count), 64'd1); tick;
      @(negedge clk);
      checkOutput("stream_empty_valid", 64'(id_valid), 64'd0);
      checkOutput("stream_hold_pc", 64'(id_pc), 64'h08);
      checkOutput("stream_empty_instr", 64'(id_instr), 64'h13);
      tick;

      $display("[TB] full and wrap");
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h10 + 32'(4 * i), 1'b1);
         tick;
      end
      applyStimulus(1'b1, 32'h20, 1'b1);
      @(negedge clk);
      checkOutput("full_count", 64'(count), 64'd4);
      checkOutput("full_if_ready", 64'(if_ready), 64'd0);
      tick;
      id_ready = 1'b1;
      @(negedge clk); checkOutput("full_reject", 64'(count), 64'd4); tick;
      @(negedge clk);
      checkOutput("full_after_pop", 64'(count), 64'd3);
      checkOutput("full_ready_again", 64'(if_ready), 64'd1);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk); checkOutput("full_pushpop", 64'(count), 64'd3); tick;
      drainWait("full_drain");

      $display("[TB] flush with drop");
      id_ready = 1'b0;
      applyStimulus(1'b1, 32'h30, 1'b0); tick;
      applyStimulus(1'b1, 32'h34, 1'b0); tick;
      flush = 1'b1; id_ready = 1'b1;
      applyStimulus(1'b1, 32'h38, 1'b0);
      @(negedge clk);
      checkOutput("flush_id_valid", 64'(id_valid), 64'd0);
      checkOutput("flush_id_instr", 64'(id_instr), 64'h13);
      tick;
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk); checkOutput("flush_count", 64'(count), 64'd0); tick;
      applyStimulus(1'b1, 32'h3C, 1'b0);
      @(negedge clk); checkOutput("drop_if_ready", 64'(if_ready), 64'd1); tick;
      applyStimulus(1'b1, 32'h100, 1'b1);
      @(negedge clk); checkOutput("drop_count", 64'(count), 64'd0); tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("after_drop_valid", 64'(id_valid), 64'd1);
      checkOutput("after_drop_pc", 64'(id_pc), 64'h100);
      tick;

      $display("[TB] interrupt during wfi");
      wfi = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b0); tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("wfi_instr", 64'(id_instr), 64'h13);
         checkOutput("wfi_valid", 64'(id_valid), 64'd1);
         checkOutput("wfi_count", 64'(count), 64'd1);
         checkOutput("wfi_pc", 64'(id_pc), 64'h100);
         tick;
      end
      interrupt = 1'b1;
      @(negedge clk); checkOutput("irq_id_valid", 64'(id_valid), 64'd0); tick;
      interrupt = 1'b0; wfi = 1'b0;
      @(negedge clk);
      checkOutput("irq_count", 64'(count), 64'd0);
      checkOutput("irq_valid", 64'(id_valid), 64'd0);
      tick;
      applyStimulus(1'b1, 32'h44, 1'b0); tick;
      applyStimulus(1'b1, 32'h200, 1'b1); tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk); checkOutput("irq_resume_pc", 64'(id_pc), 64'h200); tick;

      $display("[TB] wfi release");
      wfi = 1'b1;
      applyStimulus(1'b1, 32'h500, 1'b1); tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk); checkOutput("wfi2_instr", 64'(id_instr), 64'h13); tick;
      wfi = 1'b0;
      @(negedge clk); checkOutput("wfi2_head_pc", 64'(id_pc), 64'h500); tick;

      $display("[TB] simultaneous push/pop");
      id_ready = 1'b0;
      applyStimulus(1'b1, 32'h400, 1'b1); tick;
      applyStimulus(1'b1, 32'h404, 1'b1); tick;
      pc = 32'h408;
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pc, 1'b1);
         pc += 4;
         @(negedge clk); checkOutput("pp_count", 64'(count), 64'd2); tick;
      end
      modelCount = 2;
      for (int i = 0; i < 8; i++) begin
         rdy      = 1'($urandom_range(0, 1));
         id_ready = rdy;
         canPush  = (modelCount < DEPTH);
         if (canPush) begin
            applyStimulus(1'b1, pc, 1'b1);
            pc += 4;
         end else begin
            applyStimulus(1'b0, 32'h0, 1'b0);
         end
         @(negedge clk); checkOutput("rand_count", 64'(count), 64'(modelCount)); tick;
         modelCount = modelCount + int'(canPush) - int'(rdy && modelCount != 0);
      end
      drainWait("rand_drain");

      $display("[TB] reset mid-operation");
      id_ready = 1'b0;
      applyStimulus(1'b1, 32'h600, 1'b0); tick;
      applyStimulus(1'b1, 32'h604, 1'b0); tick;
      applyStimulus(1'b1, 32'h608, 1'b0); tick;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("pre_reset_count", 64'(count), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_count", 64'(count), 64'd0);
      checkOutput("async_valid", 64'(id_valid), 64'd0);
      checkOutput("async_if_ready", 64'(if_ready), 64'd1);
      tick;
      rst_n = 1'b1;
      @(negedge clk); checkOutput("post_reset_count", 64'(count), 64'd0); tick;

      checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID boundary buffer. Replaces the single-entry IF/ID register with a DEPTH-entry circular instruction queue that uses valid/ready handshakes on both sides.
- Sits between the fetch stage (instruction memory / bus interface) and the decode stage.
- Absorbs bus and decode stalls without re-fetching.
- Handles redirect flush with configurable wrong-path drop count, interrupt flush and WFI bubble injection.

Parameters:
- XLEN, 32, PC width.
- DEPTH, 4, queue entries; power of 2, minimum 2.
- FLUSH_DROP, 1, number of accepted fetch words discarded after a flush or interrupt (in-flight wrong-path fetches); 0 disables dropping.
- NOP_INSTR, 32'h0000_0013, instruction presented on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch word available.
- if_pc  in  XLEN  PC of fetch word.
- if_instr  in  32  fetched instruction.
- if_ready  out  1  queue can accept a word.
- id_ready  in  1  decode accepts; low on load-use or bus stall.
- id_valid  out  1  head entry valid for decode.
- id_pc  out  XLEN  PC of head entry.
- id_instr  out  32  instruction of head entry, or NOP_INSTR.
- flush  in  1  branch taken / jump redirect.
- interrupt  in  1  interrupt redirect.
- wfi  in  1  WFI active; decode must see bubbles.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
Reset:
- Reset is asynchronous, active-low: while rst_n=0, clear rd/wr pointers, count=0, drop counter=0, id_pc hold register=0.
- Resulting outputs: if_ready=1, id_valid=0, id_instr=NOP_INSTR, id_pc=0.
- Reset asserted mid-operation discards all entries immediately.

Handshake:
- push = if_valid & if_ready.
- pop = id_valid & id_ready.
- if_ready = (count != DEPTH). It is a registered-state function only, with no combinational path from id_ready.

Queue:
- Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
- count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Push when count==DEPTH is impossible, because if_ready=0.
- Empty: id_valid=0, id_instr=NOP_INSTR, id_pc holds the PC of the last popped entry.

Output:
- Head entry is shown directly: id_pc=mem_pc[rd_ptr], id_instr=mem_instr[rd_ptr], id_valid=1.
- Minimum latency IF push -> id_valid is 1 cycle (without the optional feature).

Flush / interrupt (interrupt has priority; both act identically on the queue):
- In the asserting cycle, id_valid is forced to 0 and id_instr=NOP_INSTR, so no pop occurs.
- A push in that same cycle is discarded.
- Next edge: count=0, rd_ptr=wr_ptr, drop counter loaded with FLUSH_DROP.
- While drop counter != 0: each push is accepted (if_ready stays 1) but not written, and the counter decrements by 1.
- A new flush while dropping reloads the counter to FLUSH_DROP.
- If bus stalls hold if_valid low, the drop counter holds.

WFI:
- While wfi=1: id_valid=1, id_instr=NOP_INSTR, id_pc = hold register.
- No pop occurs regardless of id_ready; pushes continue until full.
- On deassertion, the head entry is presented unchanged.
- flush or interrupt overrides wfi.

Optional Feature:
Macro: IF_ID_QUEUE_BYPASS_EN
- Defined: when count==0, drop counter==0, if_valid=1, and no flush, interrupt or wfi, the input word is presented combinationally on id_valid/id_pc/id_instr in the same cycle.
  - If id_ready=1, the word is consumed without being written.
  - Otherwise it is written as a normal push.
  - Zero-latency path.
- Undefined: no bypass; minimum latency 1 cycle; no combinational if_* -> id_* path.

Test Plan:
- Reset and streaming: release rst_n; push PCs 0x00, 0x04, 0x08 with id_ready=1 -> id_pc sequence 0x00, 0x04, 0x08, each 1 cycle after its push; count never exceeds 1; id_instr matches the pushed words.
- Full and wrap-around: id_ready=0; push 4 words (0x10–0x1C) -> count=4, if_ready=0, 5th word not accepted. Then id_ready=1 while pushing 0x20 in the cycle count drops to 3 -> output order 0x10, 0x14, 0x18, 0x1C, 0x20; wr_ptr has wrapped.
- Flush with drop, FLUSH_DROP=1: queue holds 0x30, 0x34; assert flush together with push 0x38 -> that cycle id_valid=0 and id_instr=0x13; next cycle count=0. The next pushed word 0x3C is dropped, the following word 0x100 appears with id_valid=1.
- Interrupt during WFI: wfi=1 with entry 0x40 queued -> id_instr=0x13 for 5 cycles and count unchanged. Assert interrupt -> queue cleared. Deassert wfi and push 0x200 after the drop window -> id_pc=0x200.
- Simultaneous push/pop at count=2 -> count stays 2; the PC order is preserved across 8 cycles of random id_ready.
- Reset mid-operation: count=3; pull rst_n low asynchronously between edges -> count=0, id_valid=0, if_ready=1 immediately, before the next clk edge.
